micro_sequencer: RTL and testbench
==================================

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 Parameter ADDR_W, default 7: micro-address width.
REQ-002 Parameter STACK_DEPTH, default 4: micro-subroutine return-stack entries, legal 1..16.
REQ-003 Parameter FETCH_ADDR, default 0: fetch-routine entry address.
REQ-004 Parameter INDIRECT_ADDR, default 2: indirect-cycle entry address.
REQ-005 i_clk  in  1  sole clock, rising edge.
REQ-006 i_rst_n  in  1  asynchronous, active-low reset.
REQ-007 i_cpu_start  in  1  run enable; 0 freezes all state.
REQ-008 i_step_mode  in  1  1 = single-instruction stepping.
REQ-009 i_next_instr  in  1  step stimulus, one-cycle pulse.
REQ-010 i_halt  in  1  HALT control bit.
REQ-011 i_indirect  in  1  current instruction needs an indirect cycle (IR MSB).
REQ-012 i_seq_op  in  3  sequencing op from the control word.
REQ-013 i_cond_sel  in  2  branch condition select.
REQ-014 i_branch_addr  in  ADDR_W  branch/call target from the control word.
REQ-015 i_map_addr  in  ADDR_W  execute-routine entry from the opcode map.
REQ-016 i_zf, i_nf  in  1 each  ALU zero/negative flags.
REQ-017 o_car  out  ADDR_W  current micro-address; forced 0 while i_cpu_start=0.
REQ-018 o_stack_level  out  $clog2(STACK_DEPTH+1)  occupied stack entries.
REQ-019 o_waiting  out  1  1 while FETCH is stalled by halt or stepping.
REQ-020 o_stack_ovf, o_stack_unf  out  1 each  sticky error flags.

Function
REQ-021 Only when i_cpu_start=1 shall CAR, stack, indirect_done and error flags update at a rising edge.
REQ-022 Priority 1: i_indirect=1 and indirect_done=0 -> CAR<=INDIRECT_ADDR, indirect_done<=1, i_seq_op ignored.
REQ-023 Otherwise i_seq_op decodes: 000 HOLD, 001 INC, 010 MAP, 011 FETCH, 100 BRANCH, 101 CALL, 110 RET, 111 reserved = HOLD.
REQ-024 INC: CAR<=CAR+1 modulo 2^ADDR_W (all-ones wraps to 0).
REQ-025 MAP: CAR<=i_map_addr.
REQ-026 BRANCH: cond 00 always, 01 ZF, 10 !ZF&&!NF, 11 NF; true -> CAR<=i_branch_addr, false -> CAR<=FETCH_ADDR with FETCH side effects (REQ-030).
REQ-027 CALL, level<STACK_DEPTH: push CAR+1 (wrapped), CAR<=i_branch_addr, level+1, same edge.
REQ-028 CALL, stack full: no push, CAR held, o_stack_ovf<=1.
REQ-029 RET: level>0 -> CAR<=top, level-1; level=0 -> CAR<=FETCH_ADDR, o_stack_unf<=1.
REQ-030 FETCH: i_halt=1 -> CAR held; else i_step_mode=1 and i_next_instr=0 -> CAR held; else CAR<=FETCH_ADDR, indirect_done<=0, level<=0.
REQ-031 o_waiting combinational: 1 iff i_cpu_start=1, indirect preemption inactive, op FETCH, transition blocked per REQ-030.
REQ-032 i_halt outranks stepping; i_next_instr is ignored except during FETCH.
REQ-033 Condition flags are sampled in the same cycle as the BRANCH op; zero-cycle decision latency.
REQ-034 Error flags are cleared only by reset.

Reset
REQ-035 Async i_rst_n=0: CAR=FETCH_ADDR, level=0, stack contents don't-care, indirect_done=0, o_stack_ovf=o_stack_unf=0, immediately, independent of clock.
REQ-036 Reset asserted mid-CALL/RET or mid-indirect shall abandon the operation with no partial stack update visible after release.
REQ-037 First post-release edge shall act on inputs normally.

Verification
REQ-038 Start=1, INC x3 from reset -> o_car 0,1,2,3; start=0 -> o_car=0, internal CAR held at 3, resumes 4.
REQ-039 CAR=0x05, i_indirect=1, op=MAP(0x0B) -> next 0x02; then MAP -> 0x0B; FETCH -> 0x00, indirect re-armed.
REQ-040 CAR=0x10 CALL 0x40 -> 0x40, level 1; RET -> 0x11, level 0; RET again -> 0x00, o_stack_unf=1.
REQ-041 Five nested CALLs, depth 4 -> fifth holds CAR, o_stack_ovf=1, level=4.
REQ-042 BRANCH cond 10 target 0x11: ZF=0,NF=0 -> 0x11; NF=1 -> 0x00.
REQ-043 Step mode, FETCH at 0x14: o_waiting=1 and CAR held until i_next_instr pulse -> 0x00; with i_halt=1 the pulse is ignored.

Source files
------------

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: computes the next control-address register (CAR) value from the
// sequencing op, with indirect-cycle preemption, a micro-subroutine return stack and FETCH stalls.
module micro_sequencer #(
    parameter int unsigned ADDR_W        = 7,
    parameter int unsigned STACK_DEPTH   = 4,
    parameter int unsigned FETCH_ADDR    = 0,
    parameter int unsigned INDIRECT_ADDR = 2
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_cpu_start,
    input  logic                               i_step_mode,
    input  logic                               i_next_instr,
    input  logic                               i_halt,
    input  logic                               i_indirect,
    input  logic [2:0]                         i_seq_op,
    input  logic [1:0]                         i_cond_sel,
    input  logic [ADDR_W-1:0]                  i_branch_addr,
    input  logic [ADDR_W-1:0]                  i_map_addr,
    input  logic                               i_zf,
    input  logic                               i_nf,
    output logic [ADDR_W-1:0]                  o_car,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   o_stack_level,
    output logic                               o_waiting,
    output logic                               o_stack_ovf,
    output logic                               o_stack_unf
);

    localparam int unsigned LVL_W = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [ADDR_W-1:0] FetchA    = ADDR_W'(FETCH_ADDR);
    localparam logic [ADDR_W-1:0] IndirectA = ADDR_W'(INDIRECT_ADDR);
    localparam logic [LVL_W-1:0]  LvlFull   = LVL_W'(STACK_DEPTH);

    typedef enum logic [2:0] {
        SeqHold   = 3'b000,
        SeqInc    = 3'b001,
        SeqMap    = 3'b010,
        SeqFetch  = 3'b011,
        SeqBranch = 3'b100,
        SeqCall   = 3'b101,
        SeqRet    = 3'b110,
        SeqRsvd   = 3'b111
    } seq_op_e;

    logic [ADDR_W-1:0] car_q, car_d, car_inc;
    logic [LVL_W-1:0]  lvl_q, lvl_d;
    logic              ind_done_q, ind_done_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              push_en, stall, cond_true, ind_pre;
    logic [IDX_W-1:0]  push_idx, pop_idx;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    assign car_inc  = car_q + 1'b1;
    assign push_idx = IDX_W'(lvl_q);
    assign pop_idx  = IDX_W'(lvl_q - 1'b1);
    assign ind_pre  = i_indirect && !ind_done_q;

    always_comb begin
        cond_true = 1'b1;
        case (i_cond_sel)
            2'b00:   cond_true = 1'b1;
            2'b01:   cond_true = i_zf;
            2'b10:   cond_true = !i_zf && !i_nf;
            default: cond_true = i_nf;
        endcase
    end

    always_comb begin
        car_d      = car_q;
        lvl_d      = lvl_q;
        ind_done_d = ind_done_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        push_en    = 1'b0;
        stall      = 1'b0;
        if (ind_pre) begin
            car_d      = IndirectA;
            ind_done_d = 1'b1;
        end else begin
            case (seq_op_e'(i_seq_op))
                SeqInc: car_d = car_inc;
                SeqMap: car_d = i_map_addr;
                SeqFetch: begin
                    // Halt outranks stepping; a step pulse only releases an unhalted FETCH.
                    if (i_halt || (i_step_mode && !i_next_instr)) begin
                        stall = 1'b1;
                    end else begin
                        car_d      = FetchA;
                        ind_done_d = 1'b0;
                        lvl_d      = '0;
                    end
                end
                SeqBranch: begin
                    if (cond_true) begin
                        car_d = i_branch_addr;
                    end else begin
                        car_d      = FetchA;
                        ind_done_d = 1'b0;
                        lvl_d      = '0;
                    end
                end
                SeqCall: begin
                    if (lvl_q < LvlFull) begin
                        push_en = 1'b1;
                        car_d   = i_branch_addr;
                        lvl_d   = lvl_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                SeqRet: begin
                    if (lvl_q != '0) begin
                        car_d = stack_q[pop_idx];
                        lvl_d = lvl_q - 1'b1;
                    end else begin
                        car_d = FetchA;
                        unf_d = 1'b1;
                    end
                end
                default: ; // HOLD and reserved
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            car_q      <= FetchA;
            lvl_q      <= '0;
            ind_done_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else if (i_cpu_start) begin
            car_q      <= car_d;
            lvl_q      <= lvl_d;
            ind_done_q <= ind_done_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Stack contents need no reset; only the level qualifies them.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && i_cpu_start && push_en) begin
            stack_q[push_idx] <= car_inc;
        end
    end

    assign o_car         = i_cpu_start ? car_q : '0;
    assign o_stack_level = lvl_q;
    assign o_waiting     = i_cpu_start && stall;
    assign o_stack_ovf   = ovf_q;
    assign o_stack_unf   = unf_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: expected state is queued per clock and checked after the edge.
module tb_micro_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cpu_start, step_mode, next_instr, halt, indirect, zf, nf;
    logic [2:0] seq_op;
    logic [1:0] cond_sel;
    logic [6:0] branch_addr, map_addr;
    logic [6:0] car;
    logic [2:0] stack_level;
    logic       waiting, stack_ovf, stack_unf;

    typedef struct packed {
        logic [6:0] car;
        logic [2:0] lvl;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    localparam logic [2:0] OpHold = 3'b000, OpInc = 3'b001, OpMap = 3'b010, OpFetch = 3'b011,
                           OpBranch = 3'b100, OpCall = 3'b101, OpRet = 3'b110;

    micro_sequencer #(
        .ADDR_W       (7),
        .STACK_DEPTH  (4),
        .FETCH_ADDR   (0),
        .INDIRECT_ADDR(2)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cpu_start  (cpu_start),
        .i_step_mode  (step_mode),
        .i_next_instr (next_instr),
        .i_halt       (halt),
        .i_indirect   (indirect),
        .i_seq_op     (seq_op),
        .i_cond_sel   (cond_sel),
        .i_branch_addr(branch_addr),
        .i_map_addr   (map_addr),
        .i_zf         (zf),
        .i_nf         (nf),
        .o_car        (car),
        .o_stack_level(stack_level),
        .o_waiting    (waiting),
        .o_stack_ovf  (stack_ovf),
        .o_stack_unf  (stack_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue the expected post-edge state, clock once, then pop and compare.
    task automatic tick(input string tag, input logic [6:0] e_car, input logic [2:0] e_lvl,
                        input logic e_ovf, input logic e_unf);
        exp_t e;
        sb.push_back('{car: e_car, lvl: e_lvl, ovf: e_ovf, unf: e_unf});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".car"}, 32'(car), 32'(e.car));
        chk({tag, ".lvl"}, 32'(stack_level), 32'(e.lvl));
        chk({tag, ".ovf"}, 32'(stack_ovf), 32'(e.ovf));
        chk({tag, ".unf"}, 32'(stack_unf), 32'(e.unf));
    endtask

    task automatic op(input logic [2:0] o, input logic [6:0] tgt);
        seq_op      = o;
        branch_addr = tgt;
        map_addr    = tgt;
    endtask

    initial begin
        rst_n = 1'b0; cpu_start = 1'b1; step_mode = 1'b0; next_instr = 1'b0; halt = 1'b0;
        indirect = 1'b0; zf = 1'b0; nf = 1'b0; cond_sel = 2'b00; op(OpHold, 7'h00);
        #2;
        chk("rst.car", 32'(car), 32'h0);
        chk("rst.lvl", 32'(stack_level), 32'h0);
        chk("rst.flags", {30'h0, stack_ovf, stack_unf}, 32'h0);
        chk("rst.wait", 32'(waiting), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Run enable gating and INC
        op(OpInc, 7'h00);
        tick("inc1", 7'h01, 3'd0, 1'b0, 1'b0);
        tick("inc2", 7'h02, 3'd0, 1'b0, 1'b0);
        tick("inc3", 7'h03, 3'd0, 1'b0, 1'b0);
        cpu_start = 1'b0;
        tick("frozen", 7'h00, 3'd0, 1'b0, 1'b0);
        cpu_start = 1'b1; op(OpHold, 7'h00);
        tick("resume_hold", 7'h03, 3'd0, 1'b0, 1'b0);
        op(OpInc, 7'h00);
        tick("resume_inc", 7'h04, 3'd0, 1'b0, 1'b0);

        // Indirect preemption and re-arm by FETCH
        op(OpMap, 7'h05);
        tick("map05", 7'h05, 3'd0, 1'b0, 1'b0);
        indirect = 1'b1; op(OpMap, 7'h0B);
        tick("ind_preempt", 7'h02, 3'd0, 1'b0, 1'b0);
        tick("ind_done_map", 7'h0B, 3'd0, 1'b0, 1'b0);
        op(OpFetch, 7'h00);
        tick("fetch_rearm", 7'h00, 3'd0, 1'b0, 1'b0);
        op(OpInc, 7'h00);
        tick("ind_again", 7'h02, 3'd0, 1'b0, 1'b0);
        indirect = 1'b0;

        // CALL / RET / underflow
        op(OpMap, 7'h10);
        tick("map10", 7'h10, 3'd0, 1'b0, 1'b0);
        op(OpCall, 7'h40);
        tick("call40", 7'h40, 3'd1, 1'b0, 1'b0);
        op(OpRet, 7'h00);
        tick("ret", 7'h11, 3'd0, 1'b0, 1'b0);
        tick("ret_unf", 7'h00, 3'd0, 1'b0, 1'b1);

        // Nested CALLs to overflow
        op(OpCall, 7'h20);
        for (int i = 1; i <= 4; i++) tick("call_nest", 7'h20, 3'(i), 1'b0, 1'b1);
        tick("call_ovf", 7'h20, 3'd4, 1'b1, 1'b1);
        op(OpRet, 7'h00);
        tick("ret_top", 7'h21, 3'd3, 1'b1, 1'b1);
        op(OpFetch, 7'h00);
        tick("fetch_clr_lvl", 7'h00, 3'd0, 1'b1, 1'b1);

        // BRANCH cond 10, then all-ones wrap
        op(OpMap, 7'h30);
        tick("map30", 7'h30, 3'd0, 1'b1, 1'b1);
        op(OpBranch, 7'h11); cond_sel = 2'b10;
        tick("br_pos_true", 7'h11, 3'd0, 1'b1, 1'b1);
        nf = 1'b1;
        tick("br_pos_false", 7'h00, 3'd0, 1'b1, 1'b1);
        nf = 1'b0; zf = 1'b1; cond_sel = 2'b01; op(OpBranch, 7'h55);
        tick("br_zf", 7'h55, 3'd0, 1'b1, 1'b1);
        zf = 1'b0; op(OpMap, 7'h7F);
        tick("map7f", 7'h7F, 3'd0, 1'b1, 1'b1);
        op(OpInc, 7'h00);
        tick("inc_wrap", 7'h00, 3'd0, 1'b1, 1'b1);

        // Step mode and halt
        step_mode = 1'b1; op(OpMap, 7'h14);
        tick("map14", 7'h14, 3'd0, 1'b1, 1'b1);
        op(OpFetch, 7'h00);
        #1 chk("wait_step", 32'(waiting), 32'h1);
        tick("step_hold", 7'h14, 3'd0, 1'b1, 1'b1);
        halt = 1'b1; next_instr = 1'b1;
        #1 chk("wait_halt", 32'(waiting), 32'h1);
        tick("halt_hold", 7'h14, 3'd0, 1'b1, 1'b1);
        halt = 1'b0;
        #1 chk("wait_go", 32'(waiting), 32'h0);
        tick("step_go", 7'h00, 3'd0, 1'b1, 1'b1);
        next_instr = 1'b0; step_mode = 1'b0;

        // Async reset mid-CALL, then normal first edge
        op(OpMap, 7'h22);
        tick("map22", 7'h22, 3'd0, 1'b1, 1'b1);
        op(OpCall, 7'h60);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.car", 32'(car), 32'h0);
        chk("arst.lvl", 32'(stack_level), 32'h0);
        chk("arst.flags", {30'h0, stack_ovf, stack_unf}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; op(OpInc, 7'h00);
        tick("post_rst", 7'h01, 3'd0, 1'b0, 1'b0);
        op(OpRet, 7'h00);
        tick("post_rst_ret", 7'h00, 3'd0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
